// File: rtl/fifo_tx_sched_if.sv
// fifo_tx_sched_if: FIFO status/data and UART line signals of the TX drain scheduler.
interface fifo_tx_sched_if #(parameter int WIDTH = 8);
  logic             tx_en;
  logic             fifo_empty;
  logic             fifo_out_valid;
  logic [WIDTH-1:0] fifo_output;
  logic             fifo_read_en;
  logic             tx;
  logic             tx_busy;
  logic             frame_done;
  logic             rd_err;
  logic [15:0]      tx_count;
  modport master (
    output tx_en, fifo_empty, fifo_out_valid, fifo_output,
    input  fifo_read_en, tx, tx_busy, frame_done, rd_err, tx_count
  );
  modport slave (
    input  tx_en, fifo_empty, fifo_out_valid, fifo_output,
    output fifo_read_en, tx, tx_busy, frame_done, rd_err, tx_count
  );
endinterface

// File: rtl/fifo_tx_sched.sv
// fifo_tx_sched: drains the TX byte FIFO and serializes each byte as an 8N1 UART frame.
// Define TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_tx_sched #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input logic            clk,
  input logic            rst,
  fifo_tx_sched_if.slave b
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] BEND = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BPRE = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, PARITY, STOP} state_t;
  state_t           state;
  logic [CW-1:0]    baud;
  logic [BW-1:0]    bit_idx;
  logic [1:0]       wcnt;
  logic [WIDTH-1:0] shift;
  logic             bit_end;
`ifdef TX_PARITY_EN
  logic             par;
`endif
  assign bit_end = baud == BEND;
  // Outputs are assigned alongside each transition so they describe the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      baud           <= '0;
      bit_idx        <= '0;
      wcnt           <= '0;
      shift          <= '0;
      b.tx           <= 1'b1;
      b.fifo_read_en <= 1'b0;
      b.tx_busy      <= 1'b0;
      b.frame_done   <= 1'b0;
      b.rd_err       <= 1'b0;
      b.tx_count     <= '0;
`ifdef TX_PARITY_EN
      par            <= 1'b0;
`endif
    end else begin
      b.fifo_read_en <= 1'b0;
      b.frame_done   <= 1'b0;
      b.rd_err       <= 1'b0;
      baud           <= baud + 1'b1;
      case (state)
        IDLE: if (b.tx_en && !b.fifo_empty) begin
          state          <= REQ;
          b.fifo_read_en <= 1'b1;
          b.tx_busy      <= 1'b1;
          baud           <= '0;
        end
        REQ: begin
          state <= WAIT;
          wcnt  <= '0;
          baud  <= '0;
        end
        WAIT: if (b.fifo_out_valid) begin
          state   <= START;
          shift   <= b.fifo_output;
          bit_idx <= '0;
          baud    <= '0;
          b.tx    <= 1'b0;
`ifdef TX_PARITY_EN
          par     <= ^b.fifo_output;
`endif
        end else if (wcnt == 2'd2) begin
          state     <= IDLE;
          b.tx_busy <= 1'b0;
          baud      <= '0;
        end else begin
          wcnt     <= wcnt + 1'b1;
          b.rd_err <= wcnt == 2'd1;
        end
        START: if (bit_end) begin
          state <= DATA;
          baud  <= '0;
          b.tx  <= shift[0];
        end
        DATA: if (bit_end) begin
          baud  <= '0;
          shift <= shift >> 1;
          if (bit_idx == LAST) begin
`ifdef TX_PARITY_EN
            state <= PARITY;
            b.tx  <= par;
`else
            state <= STOP;
            b.tx  <= 1'b1;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
            b.tx    <= shift[1];
          end
        end
`ifdef TX_PARITY_EN
        PARITY: if (bit_end) begin
          state <= STOP;
          baud  <= '0;
          b.tx  <= 1'b1;
        end
`endif
        STOP: begin
          if (baud == BPRE) begin
            b.frame_done <= 1'b1;
            b.tx_count   <= b.tx_count + 16'd1;
          end
          if (bit_end) begin
            state     <= IDLE;
            b.tx_busy <= 1'b0;
            baud      <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          b.tx      <= 1'b1;
          b.tx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_tx_sched.sv
// tb_fifo_tx_sched: directed checks of the FIFO drain scheduler with a behavioural one-cycle-latency FIFO.
module tb_fifo_tx_sched;
  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 0;
  logic rst = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   rd_cnt = 0;
  int   fd_cnt = 0;
  int   rd_adj = 0;
  logic prev_rd = 0;
  logic suppress = 0;
  logic pend = 0;
  logic [W-1:0] pend_data = '0;
  logic [W-1:0] q[$];
  fifo_tx_sched_if #(.WIDTH(W)) b ();
  fifo_tx_sched #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  // FIFO model: data valid in the cycle after the read strobe, plus line monitors.
  always @(negedge clk) begin
    b.fifo_out_valid = pend;
    if (pend) b.fifo_output = pend_data;
    pend = 1'b0;
    if (b.fifo_read_en && !suppress && q.size() > 0) begin
      pend      = 1'b1;
      pend_data = q.pop_front();
    end
    b.fifo_empty = q.size() == 0;
    if (b.fifo_read_en) rd_cnt++;
    if (b.fifo_read_en && prev_rd) rd_adj++;
    prev_rd = b.fifo_read_en;
    if (b.frame_done) fd_cnt++;
  end
  function automatic logic exp_bit(input logic [W-1:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= W) return d[i-1];
    if (NB == 11 && i == W + 1) return ^d;
    return 1'b1;
  endfunction
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 0;
    tick();
    tick();
    rst = 1;
    tick();
  endtask
  task automatic wait_start(input string name);
    for (int i = 0; i < 60 && b.tx !== 1'b0; i++) tick();
    n_chk++;
    if (b.tx !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: start bit timeout, tx=%b required 0", name, b.tx);
    end
  endtask
  task automatic test_reset();
    rst = 0;
    tick();
    tick();
    n_chk += 6;
    if (b.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", b.tx); end
    if (b.fifo_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", b.fifo_read_en); end
    if (b.tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", b.tx_busy); end
    if (b.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", b.frame_done); end
    if (b.rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_rderr: got %b want 0", b.rd_err); end
    if (b.tx_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", b.tx_count); end
    rst = 1;
    tick();
  endtask
  task automatic test_idle();
    int r0;
    r0 = rd_cnt;
    b.tx_en = 1;
    for (int i = 0; i < 100; i++) begin
      n_chk += 2;
      if (b.tx !== 1'b1) begin n_fail++; $display("FAIL idle_empty_tx: cyc %0d got %b want 1", i, b.tx); end
      if (b.tx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_empty_busy: cyc %0d got %b want 0", i, b.tx_busy); end
      tick();
    end
    b.tx_en = 0;
    q.push_back(8'h33);
    for (int i = 0; i < 100; i++) begin
      n_chk += 2;
      if (b.tx !== 1'b1) begin n_fail++; $display("FAIL idle_dis_tx: cyc %0d got %b want 1", i, b.tx); end
      if (b.tx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_dis_busy: cyc %0d got %b want 0", i, b.tx_busy); end
      tick();
    end
    n_chk++;
    if (rd_cnt !== r0) begin n_fail++; $display("FAIL idle_rd: got %0d pulses want 0", rd_cnt - r0); end
    q.delete();
    tick();
    tick();
  endtask
  task automatic test_single();
    int r0, f0;
    r0 = rd_cnt;
    f0 = fd_cnt;
    q.push_back(8'hA5);
    b.tx_en = 1;
    wait_start("single");
    for (int i = 0; i < NB; i++)
      for (int c = 0; c < CPB; c++) begin
        n_chk += 2;
        if (b.tx !== exp_bit(8'hA5, i)) begin n_fail++; $display("FAIL single_bit%0d: cyc %0d got %b want %b", i, c, b.tx, exp_bit(8'hA5, i)); end
        if (b.frame_done !== (i == NB - 1 && c == CPB - 1)) begin n_fail++; $display("FAIL single_fd: bit %0d cyc %0d got %b", i, c, b.frame_done); end
        tick();
      end
    b.tx_en = 0;
    repeat (4) tick();
    n_chk += 4;
    if (rd_cnt - r0 !== 1) begin n_fail++; $display("FAIL single_rd: got %0d want 1", rd_cnt - r0); end
    if (fd_cnt - f0 !== 1) begin n_fail++; $display("FAIL single_fdcnt: got %0d want 1", fd_cnt - f0); end
    if (b.tx_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", b.tx_count); end
    if (b.tx !== 1'b1) begin n_fail++; $display("FAIL single_idle_tx: got %b want 1", b.tx); end
  endtask
  task automatic test_back_to_back();
    logic [W-1:0] d[3] = '{8'h01, 8'h02, 8'h03};
    int r0, a0, gap;
    do_reset();
    r0 = rd_cnt;
    a0 = rd_adj;
    foreach (d[k]) q.push_back(d[k]);
    b.tx_en = 1;
    for (int f = 0; f < 3; f++) begin
      if (f == 0) wait_start("b2b");
      else begin
        gap = 0;
        while (b.tx === 1'b1 && gap < 20) begin gap++; tick(); end
        n_chk++;
        if (gap !== 3) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d idle cycles want 3", f, gap); end
      end
      for (int i = 0; i < NB; i++)
        for (int c = 0; c < CPB; c++) begin
          n_chk++;
          if (b.tx !== exp_bit(d[f], i)) begin n_fail++; $display("FAIL b2b_f%0d_bit%0d: got %b want %b", f, i, b.tx, exp_bit(d[f], i)); end
          tick();
        end
    end
    repeat (6) tick();
    b.tx_en = 0;
    n_chk += 5;
    if (b.tx_count !== 16'd3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", b.tx_count); end
    if (rd_cnt - r0 !== 3) begin n_fail++; $display("FAIL b2b_rd: got %0d want 3", rd_cnt - r0); end
    if (rd_adj !== a0) begin n_fail++; $display("FAIL b2b_rd_adjacent: got %0d want 0", rd_adj - a0); end
    if (q.size() !== 0) begin n_fail++; $display("FAIL b2b_fifo: got %0d entries want 0", q.size()); end
    if (b.tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", b.tx_busy); end
  endtask
  task automatic test_timeout();
    logic [15:0] c0;
    c0 = b.tx_count;
    suppress = 1;
    q.push_back(8'h77);
    b.tx_en = 1;
    for (int i = 0; i < 20 && b.fifo_read_en !== 1'b1; i++) tick();
    n_chk++;
    if (b.fifo_read_en !== 1'b1) begin n_fail++; $display("FAIL to_req: read_en=%b want 1", b.fifo_read_en); end
    for (int w = 1; w <= 3; w++) begin
      tick();
      if (w == 3) b.tx_en = 0;
      n_chk += 3;
      if (b.rd_err !== (w == 3)) begin n_fail++; $display("FAIL to_rderr_w%0d: got %b want %b", w, b.rd_err, w == 3); end
      if (b.tx !== 1'b1) begin n_fail++; $display("FAIL to_tx_w%0d: got %b want 1", w, b.tx); end
      if (b.tx_busy !== 1'b1) begin n_fail++; $display("FAIL to_busy_w%0d: got %b want 1", w, b.tx_busy); end
    end
    tick();
    n_chk += 4;
    if (b.rd_err !== 1'b0) begin n_fail++; $display("FAIL to_rderr_idle: got %b want 0", b.rd_err); end
    if (b.tx_busy !== 1'b0) begin n_fail++; $display("FAIL to_busy_idle: got %b want 0", b.tx_busy); end
    if (b.tx !== 1'b1) begin n_fail++; $display("FAIL to_tx_idle: got %b want 1", b.tx); end
    if (b.tx_count !== c0) begin n_fail++; $display("FAIL to_count: got %0d want %0d", b.tx_count, c0); end
    q.delete();
    suppress = 0;
    tick();
    tick();
  endtask
  task automatic test_reset_mid();
    int f0;
    q.push_back(8'h5A);
    b.tx_en = 1;
    wait_start("rstmid");
    repeat (CPB * 4) tick();
    f0 = fd_cnt;
    n_chk++;
    if (b.tx !== exp_bit(8'h5A, 4)) begin n_fail++; $display("FAIL rstmid_bit3: got %b want %b", b.tx, exp_bit(8'h5A, 4)); end
    rst = 0;
    b.tx_en = 0;
    tick();
    n_chk += 4;
    if (b.tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", b.tx); end
    if (b.tx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", b.tx_busy); end
    if (b.tx_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", b.tx_count); end
    if (b.frame_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_fd: got %b want 0", b.frame_done); end
    rst = 1;
    repeat (CPB * 10) tick();
    n_chk += 2;
    if (fd_cnt !== f0) begin n_fail++; $display("FAIL rstmid_fdcnt: got %0d pulses want 0", fd_cnt - f0); end
    if (b.tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle_tx: got %b want 1", b.tx); end
  endtask
`ifdef TX_PARITY_EN
  task automatic test_parity();
    int len;
    q.push_back(8'h07);
    b.tx_en = 1;
    wait_start("parity");
    repeat (CPB * 9) tick();
    for (int c = 0; c < CPB; c++) begin
      n_chk++;
      if (b.tx !== 1'b1) begin n_fail++; $display("FAIL parity_bit: cyc %0d got %b want 1", c, b.tx); end
      tick();
    end
    len = 0;
    while (b.frame_done !== 1'b1 && len < 20) begin len++; tick(); end
    n_chk++;
    if (len !== CPB - 1) begin n_fail++; $display("FAIL parity_len: stop ended after %0d cycles want %0d", len, CPB - 1); end
    b.tx_en = 0;
    repeat (4) tick();
  endtask
`endif
  initial begin
    b.tx_en = 0;
    b.fifo_empty = 1;
    b.fifo_out_valid = 0;
    b.fifo_output = '0;
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
`ifdef TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_tx_sched.md
# fifo_tx_sched

Drain scheduler for the byte FIFO on the UART transmit path. It watches the FIFO status and issues single-cycle read strobes. It captures each popped byte and serializes it as an 8N1 UART frame on `tx`. It sits between the FIFO and the board TX pin, so the CPU store path only has to push bytes into the FIFO.

## Interface
- `WIDTH`, 8: data bits per frame; must match the FIFO's WIDTH.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Minimum 2.
- `clk`  input  1  system clock; all logic on posedge.
- `rst`  input  1  reset, synchronous and active-low (0 = reset).
- `tx_en`  input  1  permits starting new frames.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_out_valid`  input  1  FIFO read-data valid strobe.
- `fifo_output`  input  WIDTH  FIFO read data.
- `fifo_read_en`  output  1  read strobe to the FIFO; single-cycle pulse.
- `tx`  output  1  serial line; idle high.
- `tx_busy`  output  1  high in every state except IDLE.
- `frame_done`  output  1  one-cycle pulse on the last cycle of the stop bit.
- `rd_err`  output  1  one-cycle pulse when a read times out.
- `tx_count`  output  16  frames sent since reset; wraps 0xFFFF -> 0.

## Operation
- States:
  - IDLE -> REQ when `tx_en && !fifo_empty`.
  - REQ -> WAIT, unconditionally after one cycle.
  - WAIT -> START when `fifo_out_valid` is seen.
  - WAIT -> IDLE after 3 WAIT cycles without `fifo_out_valid`. This is the timeout; `rd_err` pulses.
  - START -> DATA -> (PARITY) -> STOP -> IDLE.
- The FIFO is rising-edge triggered on `fifo_read_en`. The strobe is high only in REQ, so it is always low for at least 1 cycle between pulses.
- In WAIT, a valid cycle loads `fifo_output` into the shift register and a bit-index counter is cleared.
- `tx` per state:
  - START: 0.
  - DATA: `shift[0]`, LSB first, shifting right once per bit.
  - STOP: 1.
  - IDLE, REQ, WAIT: 1.
- Each START, DATA, PARITY and STOP bit lasts exactly `CLKS_PER_BIT` cycles. The baud counter runs 0..`CLKS_PER_BIT`-1 and is cleared on every state entry.
- DATA exits after bit index `WIDTH`-1 completes.
- `tx_count` increments on the cycle `frame_done` pulses.
- Deasserting `tx_en` mid-frame: the current frame completes; no new REQ is issued.
- `fifo_empty` asserting during a frame has no effect until the block returns to IDLE.
- `fifo_out_valid` outside WAIT is ignored.

## Timing
- Reset (`rst`=0 at posedge): state IDLE, `tx`=1, `fifo_read_en`=0, `tx_busy`=0, `frame_done`=0, `rd_err`=0, `tx_count`=0. The shift register and counters are cleared.
- Reset mid-frame forces `tx`=1 the following cycle and aborts the frame without a `frame_done` pulse.
- Cycle N: IDLE sees a non-empty FIFO.
- N+1: REQ, `fifo_read_en`=1.
- N+2: WAIT. `fifo_out_valid` is expected here because the FIFO has one cycle of latency.
- N+3: START, first cycle of `tx`=0.
- Frame length on the line: (`WIDTH`+2)·`CLKS_PER_BIT` cycles, plus `CLKS_PER_BIT` with parity.
- Back-to-back frames: after STOP ends, the line stays idle high for 3 cycles (IDLE, REQ, WAIT) before the next start bit.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `TX_PARITY_EN`: when defined, a PARITY state between DATA and STOP drives even parity, the XOR of the `WIDTH` data bits, for one bit time. The frame becomes 8E1.
- When undefined, DATA goes directly to STOP and the frame is 8N1.

## Test plan
- Single byte, `CLKS_PER_BIT`=4, FIFO holds 0xA5:
  - One `fifo_read_en` pulse.
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - `frame_done` pulses once; `tx_count`=1.
- FIFO holds 0x01, 0x02, 0x03:
  - Three read pulses, each separated by a low cycle.
  - Three frames with exactly 3 idle-high cycles between them.
  - `tx_count`=3; the FIFO ends empty.
- FIFO empty, or `tx_en`=0 with data present, for 100 cycles: no `fifo_read_en`, `tx` stays 1, `tx_busy`=0.
- `fifo_out_valid` held low after REQ: `rd_err` pulses on the 3rd WAIT cycle, the state returns to IDLE, `tx` never drops, and `tx_count` is unchanged.
- `rst`=0 during DATA bit 3 of 0x5A: the next cycle has `tx`=1, `tx_busy`=0, `tx_count`=0, and no `frame_done`.
- With `TX_PARITY_EN` defined, byte 0x07: after the data bits, the parity bit is 1 for 4 cycles, then the stop bit; the frame is 11 bits long.
